// File: rtl/rect_ctl.sv
// rect_ctl: mouse-positioned rectangle that drops under gravity on a button
// press. Tracks the pointer in IDLE, falls on frame ticks, and optionally
// bounces off the floor when RECT_CTL_BOUNCE_EN is defined.
module rect_ctl #(
  parameter int RECT_WIDTH    = 64,
  parameter int RECT_HEIGHT   = 64,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int ACCEL         = 1,
  parameter int MIN_VEL       = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        vsync_in,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving
);

  localparam logic [11:0] X_MAX = 12'(SCREEN_WIDTH - RECT_WIDTH);
  localparam logic [11:0] FLOOR = 12'(SCREEN_HEIGHT - RECT_HEIGHT);

  typedef enum logic [1:0] {IDLE, FALL, RISE, STOP} state_t;

  state_t      r_state, w_state_next;
  logic        r_vs_d1, r_vs_d2;
  logic        r_ml_d1, r_ml_d2;
  logic [1:0]  r_ml_arm;
  logic        w_tick, w_press;
  logic [11:0] r_xpos, r_ypos, r_vel;
  logic [11:0] w_xpos_next, w_ypos_next, w_vel_next;
  logic        r_moving;
  logic [11:0] w_x_clamp, w_y_clamp;
  logic [12:0] w_vel_n, w_fall_sum;
`ifdef RECT_CTL_BOUNCE_EN
  logic [12:0] w_vel_bounce;
  logic [11:0] w_vel_dec;
`endif

  // Registered edge detectors for frame tick and button press
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vs_d1  <= 1'b0;
      r_vs_d2  <= 1'b0;
      r_ml_d1  <= 1'b0;
      r_ml_d2  <= 1'b0;
      r_ml_arm <= '0;
    end else begin
      r_vs_d1  <= vsync_in;
      r_vs_d2  <= r_vs_d1;
      r_ml_d1  <= mouse_left;
      r_ml_d2  <= r_ml_d1;
      r_ml_arm <= {r_ml_arm[0], 1'b1};
    end
  end

  // The arm shift keeps a button already held at reset release from
  // looking like a fresh press while r_ml_d2 still holds its reset value.
  assign w_tick  = r_vs_d1 & ~r_vs_d2;
  assign w_press = r_ml_d1 & ~r_ml_d2 & r_ml_arm[1];

  assign w_x_clamp  = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
  assign w_y_clamp  = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
  assign w_vel_n    = {1'b0, r_vel} + 13'(ACCEL);
  assign w_fall_sum = {1'b0, r_ypos} + w_vel_n;
`ifdef RECT_CTL_BOUNCE_EN
  assign w_vel_bounce = w_vel_n - (w_vel_n >> 2);
  assign w_vel_dec    = (r_vel > 12'(ACCEL)) ? (r_vel - 12'(ACCEL)) : '0;
`endif

  // Next-state and motion update
  always_comb begin
    w_state_next = r_state;
    w_xpos_next  = r_xpos;
    w_ypos_next  = r_ypos;
    w_vel_next   = r_vel;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state_next = FALL;
          w_vel_next   = '0;
        end else begin
          w_xpos_next = w_x_clamp;
          w_ypos_next = w_y_clamp;
        end
      end
      FALL: begin
        if (w_tick) begin
          if (w_fall_sum >= {1'b0, FLOOR}) begin
            w_ypos_next = FLOOR;
`ifdef RECT_CTL_BOUNCE_EN
            if (w_vel_bounce < 13'(MIN_VEL)) begin
              w_state_next = STOP;
              w_vel_next   = '0;
            end else begin
              w_state_next = RISE;
              w_vel_next   = w_vel_bounce[11:0];
            end
`else
            w_state_next = STOP;
            w_vel_next   = '0;
`endif
          end else begin
            w_ypos_next = w_fall_sum[11:0];
            w_vel_next  = w_vel_n[11:0];
          end
        end
      end
`ifdef RECT_CTL_BOUNCE_EN
      RISE: begin
        if (w_tick) begin
          if (r_ypos <= r_vel) begin
            w_ypos_next  = '0;
            w_vel_next   = '0;
            w_state_next = FALL;
          end else begin
            w_ypos_next = r_ypos - r_vel;
            w_vel_next  = w_vel_dec;
            if (w_vel_dec == '0) w_state_next = FALL;
          end
        end
      end
`endif
      STOP: begin
        if (w_press) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, position, velocity and moving-flag registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_xpos   <= '0;
      r_ypos   <= '0;
      r_vel    <= '0;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_xpos   <= w_xpos_next;
      r_ypos   <= w_ypos_next;
      r_vel    <= w_vel_next;
      r_moving <= (w_state_next == FALL) || (w_state_next == RISE);
    end
  end

  assign xpos   = r_xpos;
  assign ypos   = r_ypos;
  assign moving = r_moving;

endmodule

// File: tb/tb_rect_ctl.sv
// tb_rect_ctl: directed test of rect_ctl tracking, drop, floor handling,
// button edge cases and reset behaviour. Follows RECT_CTL_BOUNCE_EN.
module tb_rect_ctl;

  // With MIN_VEL=2 a rebound of 3 reproduces itself forever, so the bench
  // raises it to let the bounce sequence decay into STOP.
  localparam int TB_MIN_VEL = 4;

  logic        pclk;
  logic        rst;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        mouse_left, vsync_in;
  logic [11:0] xpos, ypos;
  logic        moving;

  int unsigned n_checks;
  int unsigned n_pass;

  rect_ctl #(
    .RECT_WIDTH   (64),
    .RECT_HEIGHT  (64),
    .SCREEN_WIDTH (800),
    .SCREEN_HEIGHT(600),
    .ACCEL        (1),
    .MIN_VEL      (TB_MIN_VEL)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left),
    .vsync_in  (vsync_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .moving    (moving)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) @(negedge pclk);
  endtask

  // one-cycle vsync pulse; returns after the tick has been applied
  task automatic frame_tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  // rising edge on mouse_left; returns after the press has been applied, button released
  task automatic press();
    mouse_left = 1'b1;
    step(2);
    mouse_left = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    mouse_xpos = '0;
    mouse_ypos = '0;
    mouse_left = 1'b0;
    vsync_in   = 1'b0;
    step(3);
    check("reset_x", 32'(xpos), 0);
    check("reset_y", 32'(ypos), 0);
    check("reset_moving", 32'(moving), 0);

    // IDLE tracking with clamping
    rst = 1'b0; mouse_xpos = 12'd900; mouse_ypos = 12'd700;
    step();
    check("track_clamp_x", 32'(xpos), 736);
    check("track_clamp_y", 32'(ypos), 536);
    mouse_xpos = 12'd100; mouse_ypos = 12'd50;
    step();
    check("track_x", 32'(xpos), 100);
    check("track_y", 32'(ypos), 50);

    // drop from (100,0)
    mouse_ypos = 12'd0;
    step();
    press();
    check("drop_moving", 32'(moving), 1);
    check("drop_y0", 32'(ypos), 0);
    step();
    check("no_tick_hold_y", 32'(ypos), 0);
    mouse_xpos = 12'd300; mouse_ypos = 12'd300;
    frame_tick(); check("fall_t1", 32'(ypos), 1);
    frame_tick(); check("fall_t2", 32'(ypos), 3);
    frame_tick(); check("fall_t3", 32'(ypos), 6);
    check("fall_x_frozen", 32'(xpos), 100);
    for (int i = 4; i <= 32; i++) frame_tick();
    check("fall_t32", 32'(ypos), 528);
    check("fall_t32_moving", 32'(moving), 1);
    frame_tick();
    check("floor_y", 32'(ypos), 536);
`ifdef RECT_CTL_BOUNCE_EN
    check("floor_rise_moving", 32'(moving), 1);
    for (int i = 0; i < 3000 && moving; i++) frame_tick();
`endif
    check("stop_moving", 32'(moving), 0);
    check("stop_y", 32'(ypos), 536);

    // STOP holds position, then a press resumes tracking
    mouse_xpos = 12'd400; mouse_ypos = 12'd200;
    step(2);
    frame_tick();
    check("stop_hold_x", 32'(xpos), 100);
    check("stop_hold_y", 32'(ypos), 536);
    press();
    step();
    check("resume_x", 32'(xpos), 400);
    check("resume_y", 32'(ypos), 200);

    // press coincident with a tick: enter FALL with no motion
    mouse_xpos = 12'd200; mouse_ypos = 12'd100;
    step();
    check("pre_coinc_y", 32'(ypos), 100);
    mouse_left = 1'b1; vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
    check("coinc_y", 32'(ypos), 100);
    check("coinc_moving", 32'(moving), 1);
    mouse_left = 1'b0;
    step();

    // press during FALL is ignored
    press();
    step();
    check("fall_press_moving", 32'(moving), 1);
    check("fall_press_y", 32'(ypos), 100);
    frame_tick();
    check("fall_after_press_y", 32'(ypos), 101);

    // reset mid-fall
    rst = 1'b1;
    step(2);
    check("midreset_x", 32'(xpos), 0);
    check("midreset_y", 32'(ypos), 0);
    check("midreset_moving", 32'(moving), 0);
    mouse_left = 1'b1; mouse_xpos = 12'd50; mouse_ypos = 12'd60;
    rst = 1'b0;
    step(3);
    check("held_btn_x", 32'(xpos), 50);
    check("held_btn_y", 32'(ypos), 60);
    check("held_btn_moving", 32'(moving), 0);
    mouse_xpos = 12'd70; mouse_ypos = 12'd80;
    step();
    check("held_btn_track_x", 32'(xpos), 70);
    mouse_left = 1'b0;
    step();
    press();
    check("post_reset_press_moving", 32'(moving), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rect_ctl.md
RECT_CTL -- requirements
Module: rect_ctl

Interface
REQ-001 Parameter RECT_WIDTH, default 64: rectangle width in pixels, used for x clamping.
REQ-002 Parameter RECT_HEIGHT, default 64: rectangle height in pixels, used for the floor position.
REQ-003 Parameter SCREEN_WIDTH, default 800, and SCREEN_HEIGHT, default 600: visible area in pixels.
REQ-004 Parameter ACCEL, default 1: velocity increment per frame tick, pixels/frame.
REQ-005 Parameter MIN_VEL, default 2: rebound velocity below which motion stops.
REQ-006 Port pclk, input, 1: pixel clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Ports mouse_xpos and mouse_ypos, input, 12 each: mouse pointer position.
REQ-009 Port mouse_left, input, 1: left button level, synchronous to pclk.
REQ-010 Port vsync_in, input, 1: vertical sync from the timing chain; defines frame ticks.
REQ-011 Ports xpos and ypos, output, 12 each: registered rectangle top-left corner, fed to the draw_rect stage.
REQ-012 Port moving, output, 1: registered; high in states FALL and RISE.

Function
REQ-013 Frame tick SHALL be a one-cycle pulse, asserted the cycle after vsync_in is sampled high having been sampled low the previous cycle (registered edge detect).
REQ-014 Button press SHALL be a one-cycle pulse on a registered 0->1 edge of mouse_left.
REQ-015 States SHALL be IDLE, FALL, RISE and STOP, held in a registered state variable.
REQ-016 IDLE: every cycle, xpos <= min(mouse_xpos, SCREEN_WIDTH-RECT_WIDTH) and ypos <= min(mouse_ypos, SCREEN_HEIGHT-RECT_HEIGHT); latency is 1 cycle.
REQ-017 IDLE, on button press: go to FALL, velocity <= 0, xpos frozen; no motion update that cycle, even if a frame tick coincides.
REQ-018 FALL, on frame tick: vel_n = vel+ACCEL; if ypos+vel_n >= FLOOR (SCREEN_HEIGHT-RECT_HEIGHT), then ypos <= FLOOR and the floor-hit rule applies; else ypos <= ypos+vel_n and velocity <= vel_n.
REQ-019 Floor-hit rule, bounce build: velocity <= vel_n - (vel_n>>2); if that value < MIN_VEL, go to STOP with velocity 0, else go to RISE.
REQ-020 RISE, on frame tick: if ypos <= velocity, ypos <= 0, velocity <= 0, go to FALL; else ypos <= ypos-velocity and velocity <= velocity-ACCEL (saturating at 0); velocity reaching 0 SHALL go to FALL.
REQ-021 STOP: xpos and ypos are held; on button press, go to IDLE.
REQ-022 A button press in FALL or RISE SHALL be ignored.
REQ-023 Velocity SHALL be 12-bit unsigned; all sums SHALL be computed at 13 bits before comparison so that no wrap-around occurs.
REQ-024 Without a frame tick, FALL and RISE SHALL hold xpos, ypos and velocity.

Reset
REQ-025 While rst=1: state <= IDLE, xpos <= 0, ypos <= 0, velocity <= 0, moving <= 0, and edge-detect registers <= 0.
REQ-026 Reset asserted mid-fall or mid-rise SHALL abort motion; the first cycle after release behaves as IDLE.
REQ-027 mouse_left already high at reset release SHALL NOT generate a button press.

Configuration
REQ-028 Macro RECT_CTL_BOUNCE_EN: when defined, the floor-hit rule of REQ-019 applies and RISE is reachable.
REQ-029 Without RECT_CTL_BOUNCE_EN, a floor hit SHALL go directly to STOP with velocity 0; RISE is unreachable and may be omitted.

Verification
REQ-030 IDLE track: mouse (900,700) -> xpos=736, ypos=536 one cycle later; mouse (100,50) -> (100,50).
REQ-031 Drop: press at mouse (100,0), 3 ticks -> ypos = 1, 3, 6; xpos stays 100 after the mouse moves.
REQ-032 Floor (bounce build): fall from ypos=0 -> ypos=536 on the hit tick, state RISE, moving=1; motion ends in STOP with ypos=536, moving=0.
REQ-033 Floor (no macro): same drop -> STOP on the first hit tick, ypos=536, RISE never entered.
REQ-034 Edge cases: press coincident with a tick in IDLE -> FALL, ypos unchanged; press during FALL -> ignored; press in STOP -> IDLE tracking resumes.
REQ-035 Reset mid-FALL -> xpos=ypos=0, state IDLE; mouse_left held high through reset release -> no FALL.
